// File: rtl/axis_grey_threshold_pkg.sv
// Shared register map, CTRL bit positions and configuration types for axis_grey_threshold.
package axis_grey_threshold_pkg;

    localparam logic [3:0] ADDR_CTRL      = 4'h0;
    localparam logic [3:0] ADDR_THRESH    = 4'h4;
    localparam logic [3:0] ADDR_FRAME_CNT = 4'h8;
    localparam logic [3:0] ADDR_STAT      = 4'hC;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_INV_BIT = 1;

    localparam logic [7:0] THRESH_RST = 8'h80;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef struct packed {
        logic       en;
        logic       invert;
        logic [7:0] thresh;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = '{en: 1'b0, invert: 1'b0, thresh: THRESH_RST};

endpackage

// File: rtl/axis_skid_buffer.sv
// AXI4-Stream output register plus one skid slot; upstream ready is a flop, never a comb path.
module axis_skid_buffer #(
    parameter int W = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] s_data_i,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    output logic [W-1:0] m_data_o,
    output logic         m_valid_o,
    input  logic         m_ready_i
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         s_ready_q, s_ready_d;
    logic         s_hs;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        s_hs         = s_valid_i & s_ready_q;

        if (!out_valid_q || m_ready_i) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = s_hs;
                if (s_hs) out_data_d = s_data_i;
            end
        end else if (s_hs) begin
            // Beat accepted while the output stalls: park it, ready drops next cycle.
            skid_valid_d = 1'b1;
            skid_data_d  = s_data_i;
        end

        s_ready_d = ~skid_valid_d;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            s_ready_q    <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            s_ready_q    <= s_ready_d;
        end
    end

    assign s_ready_o = s_ready_q;
    assign m_valid_o = out_valid_q;
    assign m_data_o  = out_data_q;

endmodule

// File: rtl/axis_grey_threshold.sv
// Grey-to-binary AXI4-Stream stage with AXI4-Lite control; THRESHOLD_STATS_EN adds a per-frame
// count of high output pixels in STAT.
module axis_grey_threshold
    import axis_grey_threshold_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int TDATA_W            = 8
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [TDATA_W-1:0]              s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tuser,
    input  logic                            s_axis_tlast,
    output logic [TDATA_W-1:0]              m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tuser,
    output logic                            m_axis_tlast,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready
);

    ctrl_t                          cfg_q, cfg_d, act_q, act_d, cfg_use;
    logic                           first_q, first_d;
    logic                           s_ready, s_hs, m_hs, load_cfg, pix_hi;
    logic [TDATA_W-1:0]             pix;
    logic [TDATA_W+1:0]             m_data;
    logic                           aw_rdy_q, aw_rdy_d, bvalid_q, bvalid_d, wr_hs;
    logic                           ar_rdy_q, ar_rdy_d, rvalid_q, rvalid_d, rd_hs;
    logic [C_S_AXI_DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [31:0]                    frame_cnt_q, frame_cnt_d, stat_val;
    logic [C_S_AXI_ADDR_WIDTH-1:0]  wr_addr, rd_addr;
    logic                           unused_ok;

    assign wr_addr = {s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2], 2'b00};
    assign rd_addr = {s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2], 2'b00};

    always_comb begin
        wr_hs    = aw_rdy_q & s_axi_awvalid & s_axi_wvalid;
        aw_rdy_d = s_axi_awvalid & s_axi_wvalid & ~bvalid_q & ~aw_rdy_q;
        bvalid_d = wr_hs | (bvalid_q & ~s_axi_bready);
        rd_hs    = ar_rdy_q & s_axi_arvalid;
        ar_rdy_d = s_axi_arvalid & ~rvalid_q & ~ar_rdy_q;
        rvalid_d = rd_hs | (rvalid_q & ~s_axi_rready);

        cfg_d = cfg_q;
        if (wr_hs && s_axi_wstrb[0]) begin
            case (wr_addr)
                ADDR_CTRL: begin
                    cfg_d.en     = s_axi_wdata[CTRL_EN_BIT];
                    cfg_d.invert = s_axi_wdata[CTRL_INV_BIT];
                end
                ADDR_THRESH: cfg_d.thresh = s_axi_wdata[7:0];
                default: ;
            endcase
        end

        rdata_d = rdata_q;
        if (rd_hs) begin
            rdata_d = '0;
            case (rd_addr)
                ADDR_CTRL: begin
                    rdata_d[CTRL_EN_BIT]  = cfg_q.en;
                    rdata_d[CTRL_INV_BIT] = cfg_q.invert;
                end
                ADDR_THRESH:    rdata_d[7:0] = cfg_q.thresh;
                ADDR_FRAME_CNT: rdata_d      = frame_cnt_q;
                ADDR_STAT:      rdata_d      = stat_val;
                default: ;
            endcase
        end
    end

    // SOF beats (and the first beat after reset) see the freshly programmed set in the same cycle.
    always_comb begin
        s_hs     = s_axis_tvalid & s_ready;
        m_hs     = m_axis_tvalid & m_axis_tready;
        load_cfg = s_axis_tuser | first_q;
        cfg_use  = load_cfg ? cfg_q : act_q;
        act_d    = (s_hs && load_cfg) ? cfg_q : act_q;
        first_d  = first_q & ~s_hs;
        pix_hi   = (s_axis_tdata >= TDATA_W'(cfg_use.thresh)) ^ cfg_use.invert;
        pix      = cfg_use.en ? {TDATA_W{pix_hi}} : s_axis_tdata;
        frame_cnt_d = frame_cnt_q;
        if (m_hs && m_axis_tuser) frame_cnt_d = frame_cnt_q + 32'd1;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_rdy_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            ar_rdy_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            cfg_q       <= CTRL_RST;
            act_q       <= CTRL_RST;
            first_q     <= 1'b1;
            frame_cnt_q <= '0;
        end else begin
            aw_rdy_q    <= aw_rdy_d;
            bvalid_q    <= bvalid_d;
            ar_rdy_q    <= ar_rdy_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            cfg_q       <= cfg_d;
            act_q       <= act_d;
            first_q     <= first_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    axis_skid_buffer #(.W(TDATA_W + 2)) u_skid (
        .clk_i     (ACLK),
        .rst_i     (ARESET),
        .s_data_i  ({s_axis_tuser, s_axis_tlast, pix}),
        .s_valid_i (s_axis_tvalid),
        .s_ready_o (s_ready),
        .m_data_o  (m_data),
        .m_valid_o (m_axis_tvalid),
        .m_ready_i (m_axis_tready)
    );

`ifdef THRESHOLD_STATS_EN
    logic [31:0] hi_cnt_q, hi_cnt_d, stat_q, stat_d;
    logic        eol_seen_q, eol_seen_d, out_hi;

    // A frame closes when an SOF beat follows a beat that carried tlast.
    always_comb begin
        hi_cnt_d   = hi_cnt_q;
        stat_d     = stat_q;
        eol_seen_d = eol_seen_q;
        out_hi     = (m_axis_tdata == {TDATA_W{1'b1}});
        if (m_hs) begin
            eol_seen_d = m_axis_tlast;
            if (m_axis_tuser && eol_seen_q) begin
                stat_d   = hi_cnt_q;
                hi_cnt_d = {31'd0, out_hi};
            end else if (out_hi && hi_cnt_q != 32'hFFFF_FFFF) begin
                hi_cnt_d = hi_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            hi_cnt_q   <= '0;
            stat_q     <= '0;
            eol_seen_q <= 1'b0;
        end else begin
            hi_cnt_q   <= hi_cnt_d;
            stat_q     <= stat_d;
            eol_seen_q <= eol_seen_d;
        end
    end

    assign stat_val = stat_q;
`else
    assign stat_val = '0;
`endif

    assign s_axis_tready = s_ready;
    assign m_axis_tuser  = m_data[TDATA_W+1];
    assign m_axis_tlast  = m_data[TDATA_W];
    assign m_axis_tdata  = m_data[TDATA_W-1:0];
    assign s_axi_awready = aw_rdy_q;
    assign s_axi_wready  = aw_rdy_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = RESP_OKAY;
    assign s_axi_arready = ar_rdy_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = RESP_OKAY;

    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0],
                         s_axi_wdata[C_S_AXI_DATA_WIDTH-1:8], s_axi_wstrb[C_S_AXI_DATA_WIDTH/8-1:1]};

endmodule

// File: tb/tb_axis_grey_threshold.sv
// Randomized self-checking bench for axis_grey_threshold against a beat-level reference model.
module tb_axis_grey_threshold;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_tdata;
    logic        s_tvalid, s_tready, s_tuser, s_tlast;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tready, m_tuser, m_tlast;
    logic [3:0]  awaddr, araddr, wstrb;
    logic [31:0] wdata, rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    axis_grey_threshold dut (
        .ACLK(clk), .ARESET(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast),
        .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(3'b000), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    typedef struct {
        logic [7:0] data;
        logic       user;
        logic       last;
        int         cyc;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    rdy_mode = 0;   // 0: always ready, 1: random 50%, 2: stalled
    bit    chk_lat = 0;
    int    acc_cyc;

    // Reference model state: programmed registers and the set active for the current frame.
    logic       m_en, m_inv, a_en, a_inv;
    logic [7:0] m_th, a_th;
    bit         m_first;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_pix(input logic [7:0] p, input logic en, input logic inv,
                                           input logic [7:0] th);
        if (!en) return p;
        return ((p >= th) != inv) ? 8'hFF : 8'h00;
    endfunction

    task automatic model_reset();
        m_en = 0; m_inv = 0; m_th = 8'h80;
        a_en = 0; a_inv = 0; a_th = 8'h80;
        m_first = 1;
    endtask

    task automatic do_reset();
        rst = 1;
        s_tvalid = 0; s_tdata = 0; s_tuser = 0; s_tlast = 0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl_outs", {m_tvalid, s_tready, awready, wready, bvalid, arready, rvalid}, 0);
        check("rst_m_data", {m_tuser, m_tlast, m_tdata}, 0);
        rst = 0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic axi_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] strb);
        bit ok = 0;
        awaddr = a; wdata = d; wstrb = strb; awvalid = 1; wvalid = 1;
        for (int t = 0; t < 50 && !ok; t++) begin
            if (awready && wready) ok = 1;
            @(posedge clk); #1;
        end
        awvalid = 0; wvalid = 0;
        check("aw_w_handshake", ok, 1);
        if (ok && strb[0] && a[3:2] == 2'd0) begin m_en = d[0]; m_inv = d[1]; end
        if (ok && strb[0] && a[3:2] == 2'd1) m_th = d[7:0];
        bready = 1; ok = 0;
        for (int t = 0; t < 50 && !ok; t++) begin
            if (bvalid) begin ok = 1; check("bresp", bresp, 0); end
            @(posedge clk); #1;
        end
        bready = 0;
        check("b_handshake", ok, 1);
    endtask

    task automatic axi_rd(input logic [3:0] a, output logic [31:0] d);
        bit ok = 0;
        d = 'x;
        araddr = a; arvalid = 1;
        for (int t = 0; t < 50 && !ok; t++) begin
            if (arready) ok = 1;
            @(posedge clk); #1;
        end
        arvalid = 0;
        check("ar_handshake", ok, 1);
        rready = 1; ok = 0;
        for (int t = 0; t < 50 && !ok; t++) begin
            if (rvalid) begin ok = 1; d = rdata; check("rresp", rresp, 0); end
            @(posedge clk); #1;
        end
        rready = 0;
        check("r_handshake", ok, 1);
    endtask

    task automatic send_pix(input logic [7:0] d, input logic u, input logic l, input bit gaps);
        beat_t e;
        bit done = 0;
        if (gaps && $urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
        s_tvalid = 1; s_tdata = d; s_tuser = u; s_tlast = l;
        for (int t = 0; t < 500 && !done; t++) begin
            if (s_tready) begin
                if (u || m_first) begin a_en = m_en; a_inv = m_inv; a_th = m_th; m_first = 0; end
                e.data = ref_pix(d, a_en, a_inv, a_th);
                e.user = u; e.last = l; e.cyc = cyc;
                exp_q.push_back(e);
                acc_cyc = cyc;
                done = 1;
            end
            @(posedge clk); #1;
        end
        s_tvalid = 0;
        if (!done) check("s_ready_timeout", 0, 1);
    endtask

    task automatic send_frame(input int w, input int h, input bit gaps);
        for (int i = 0; i < w * h; i++)
            send_pix(8'($urandom_range(0, 255)), i == 0, (i % w) == w - 1, gaps);
    endtask

    task automatic drain();
        for (int t = 0; t < 2000 && exp_q.size() != 0; t++) begin @(posedge clk); #1; end
        check("drain_left", exp_q.size(), 0);
    endtask

    // Output monitor: consumes beats against the model queue, checks stall stability and latency.
    initial begin : monitor
        beat_t      e;
        logic [9:0] held;
        bit         hold;
        hold = 0;
        m_tready = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) hold = 0;
            else if (hold) check("m_stable", {m_tvalid, m_tuser, m_tlast, m_tdata}, {1'b1, held});
            case (rdy_mode)
                0:       m_tready = 1;
                1:       m_tready = 1'($urandom_range(0, 1));
                default: m_tready = 0;
            endcase
            hold = 0;
            if (!rst && m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("m_extra_beat", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("m_beat", {m_tuser, m_tlast, m_tdata}, {e.user, e.last, e.data});
                    if (chk_lat) check("latency", cyc - e.cyc, 1);
                end
            end else if (!rst && m_tvalid) begin
                hold = 1;
                held = {m_tuser, m_tlast, m_tdata};
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic [7:0] stream4[4] = '{8'h7F, 8'h80, 8'hFF, 8'h00};

    task automatic send_stream4();
        int first_acc;
        for (int i = 0; i < 4; i++) begin
            send_pix(stream4[i], i == 0, i == 3, 0);
            if (i == 0) first_acc = acc_cyc;
        end
        check("throughput", acc_cyc - first_acc, 3);
        drain();
    endtask

    initial begin : main
        logic [31:0] rd;
        logic [7:0]  px;
        int          hi_left, lo_left;

        do_reset();

        // Reset register values, readback, strobes and read-only protection.
        axi_rd(4'h0, rd); check("rst_ctrl", rd, 0);
        axi_rd(4'h4, rd); check("rst_thresh", rd, 32'h80);
        axi_rd(4'h8, rd); check("rst_frame_cnt", rd, 0);
        axi_rd(4'hC, rd); check("rst_stat", rd, 0);
        axi_wr(4'h4, 32'h5A, 4'hF);
        axi_rd(4'h4, rd); check("thresh_rb", rd, 32'h5A);
        axi_wr(4'h4, 32'h33, 4'h0);
        axi_rd(4'h4, rd); check("thresh_nostrb", rd, 32'h5A);
        axi_wr(4'h8, 32'hFFFF, 4'hF);
        axi_rd(4'h8, rd); check("ro_write_ignored", rd, 0);

        // Binarize, invert and passthrough with continuous ready and strict 1-cycle latency.
        chk_lat = 1;
        axi_wr(4'h4, 32'h80, 4'hF);
        axi_wr(4'h0, 32'h1, 4'hF);
        send_stream4();
        axi_wr(4'h0, 32'h3, 4'hF);
        send_stream4();
        axi_wr(4'h0, 32'h0, 4'hF);
        send_stream4();
        chk_lat = 0;

        // Stall the output, leave beats in flight, then reset: they must vanish.
        rdy_mode = 2;
        send_pix(8'h11, 1, 0, 0);
        send_pix(8'h22, 0, 0, 0);
        exp_q.delete();
        do_reset();
        rdy_mode = 0;

        // First beat after reset loads the programmed set even without SOF, then random traffic.
        axi_wr(4'h4, 32'($urandom_range(1, 254)), 4'hF);
        axi_wr(4'h0, 32'($urandom_range(0, 3)), 4'hF);
        send_pix(8'($urandom_range(0, 255)), 0, 0, 0);
        send_pix(8'($urandom_range(0, 255)), 0, 1, 0);
        rdy_mode = 1;
        for (int f = 0; f < 3; f++) send_frame(16, 4, 1);
        drain();
        rdy_mode = 0;
        axi_rd(4'h8, rd); check("frame_cnt", rd, 3);

        // Mid-frame THRESH write only affects the following frame.
        axi_wr(4'h0, 32'h1, 4'hF);
        axi_wr(4'h4, 32'h80, 4'hF);
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 64; i++) begin
                if (f == 0 && i == 32) axi_wr(4'h4, 32'h10, 4'hF);
                send_pix(8'($urandom_range(16, 127)), i == 0, (i % 16) == 15, 0);
            end
        end
        drain();

        // 16x4 frame with exactly 20 pixels at or above 0x80, closed by the next SOF.
        axi_wr(4'h4, 32'h80, 4'hF);
        hi_left = 20; lo_left = 44;
        for (int i = 0; i < 64; i++) begin
            if (lo_left == 0 || (hi_left != 0 && $urandom_range(0, 63) < 20)) begin
                px = 8'($urandom_range(128, 255)); hi_left--;
            end else begin
                px = 8'($urandom_range(0, 127)); lo_left--;
            end
            send_pix(px, i == 0, (i % 16) == 15, 1);
        end
        send_pix(8'h00, 1, 0, 0);
        drain();
        axi_rd(4'hC, rd);
`ifdef THRESHOLD_STATS_EN
        check("stat", rd, 20);
`else
        check("stat", rd, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
